dpu_vector_loader: RTL

- Upstream feeder for the block-floating-point dot-product unit.
- Accepts FP operand pairs (a[k], b[k]) one element per cycle over a valid/ready handshake.
- Assembles them into V-lane operand vectors in a ping-pong (two-bank) buffer and issues each vector pair as a one-cycle valid pulse on the dot-product unit's vector/vector_valid inputs.
- Zero-pads short frames and enforces a programmable minimum gap between issues, because the dot-product unit has no backpressure.

---
 rtl/dpu_vector_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dpu_vector_loader.sv
// rtl/dpu_vector_loader.sv - ping-pong operand vector assembler for the BFP dot-product unit; optional perf counters under DPU_LOADER_PERF_EN
module dpu_vector_loader #(
    parameter int V   = 4,
    parameter int BIT = 32,
    parameter int GAP = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIT-1:0]   in_a,
    input  logic [BIT-1:0]   in_b,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [V*BIT-1:0] vector,
    output logic [V*BIT-1:0] vector2,
    output logic             vector_valid,
    output logic             vector_valid2,
    output logic             vector_last
`ifdef DPU_LOADER_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);
    localparam int CW = (V > 1) ? $clog2(V) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

    bank_state_t     bank_state     [2];
    bank_state_t     bank_state_nxt [2];
    logic            bank_last      [2];
    logic [BIT-1:0]  bank_a         [2][V];
    logic [BIT-1:0]  bank_b         [2][V];
    logic            wr_bank;
    logic            iss_bank;
    logic [CW-1:0]   count;
    logic [GW-1:0]   gap_cnt;
    logic            accept;
    logic            close;
    logic            issue;

    // Ready depends only on registered bank state, never on in_valid.
    assign in_ready      = (bank_state[wr_bank] != FULL);
    assign accept        = in_valid && in_ready;
    assign close         = accept && ((count == CW'(V - 1)) || in_last);
    assign issue         = (bank_state[iss_bank] == FULL) && (gap_cnt == '0);
    assign vector_valid2 = vector_valid;

    // Bank state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
        end else begin
            bank_state[0] <= bank_state_nxt[0];
            bank_state[1] <= bank_state_nxt[1];
        end
    end

    // Bank transitions: the write bank and the issue bank can never collide here,
    // because a FULL write bank blocks accepts.
    always_comb begin
        bank_state_nxt[0] = bank_state[0];
        bank_state_nxt[1] = bank_state[1];
        if (close) begin
            bank_state_nxt[wr_bank] = FULL;
        end else if (accept) begin
            bank_state_nxt[wr_bank] = FILLING;
        end
        if (issue) begin
            bank_state_nxt[iss_bank] = EMPTY;
        end
    end

    // Fill side: write the accepted lane, zero the untouched tail lanes on close.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                bank_last[b] <= 1'b0;
                for (int j = 0; j < V; j++) begin
                    bank_a[b][j] <= '0;
                    bank_b[b][j] <= '0;
                end
            end
            wr_bank <= 1'b0;
            count   <= '0;
        end else if (accept) begin
            for (int j = 0; j < V; j++) begin
                if (j == int'(count)) begin
                    bank_a[wr_bank][j] <= in_a;
                    bank_b[wr_bank][j] <= in_b;
                end else if (close && (j > int'(count))) begin
                    bank_a[wr_bank][j] <= '0;
                    bank_b[wr_bank][j] <= '0;
                end
            end
            if (close) begin
                bank_last[wr_bank] <= in_last;
                count              <= '0;
                wr_bank            <= ~wr_bank;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Issue side: one-cycle pulse per FULL bank, then hold off for GAP cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vector       <= '0;
            vector2      <= '0;
            vector_valid <= 1'b0;
            vector_last  <= 1'b0;
            iss_bank     <= 1'b0;
            gap_cnt      <= '0;
        end else begin
            vector_valid <= 1'b0;
            if (issue) begin
                for (int k = 0; k < V; k++) begin
                    vector[k*BIT +: BIT]  <= bank_a[iss_bank][k];
                    vector2[k*BIT +: BIT] <= bank_b[iss_bank][k];
                end
                vector_valid <= 1'b1;
                vector_last  <= bank_last[iss_bank];
                iss_bank     <= ~iss_bank;
                gap_cnt      <= GW'(GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

`ifdef DPU_LOADER_PERF_EN
    // Free-running issue and input-stall counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (in_valid && !in_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
